// File: rtl/relu_argmax.sv
// Streaming argmax over one frame of NUM_CLASSES ReLU scores, valid/ready on both sides.
// Optional feature: define RELU_ARGMAX_ZERO_FLAG_EN to add the out_all_zero output.
//
// state   | meaning
// COLLECT | accepting scores, tracking running maximum
// HOLD    | frame result presented, waiting for out_ready

module relu_argmax #(
    parameter int DATA_W      = 23,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_clear,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max,
    output logic              out_valid,
    input  logic              out_ready
`ifdef RELU_ARGMAX_ZERO_FLAG_EN
    ,
    output logic              out_all_zero
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [DATA_W-1:0]  best;
    logic [IDX_W-1:0]   best_idx;
    logic               accept;
    logic               last_beat;
    logic               take;
    logic [DATA_W-1:0]  win_val;
    logic [IDX_W-1:0]   win_idx;

    assign in_ready  = (state == COLLECT);
    assign accept    = in_valid && in_ready;
    assign last_beat = accept && (cnt == LAST_IDX);

    // Strict compare keeps the lowest index on ties; first beat always seeds.
    assign take    = (cnt == '0) || (in_data > best);
    assign win_val = take ? in_data : best;
    assign win_idx = take ? cnt : best_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (in_clear) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                COLLECT: if (last_beat) state_nxt = HOLD;
                HOLD:    if (out_valid && out_ready) state_nxt = COLLECT;
                default: state_nxt = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_idx   <= '0;
            out_max   <= '0;
            out_valid <= 1'b0;
        end else if (in_clear) begin
            cnt       <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            if (take) begin
                best     <= in_data;
                best_idx <= cnt;
            end
            if (last_beat) begin
                cnt       <= '0;
                out_max   <= win_val;
                out_idx   <= win_idx;
                out_valid <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RELU_ARGMAX_ZERO_FLAG_EN
    // A zero winner means every score in the frame was zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_all_zero <= 1'b0;
        end else if (in_clear) begin
            out_all_zero <= 1'b0;
        end else if (last_beat) begin
            out_all_zero <= (win_val == '0);
        end else if (out_valid && out_ready) begin
            out_all_zero <= 1'b0;
        end
    end
`else
    // Zero-activation flag not built.
`endif

endmodule

// File: tb/tb_relu_argmax.sv
// Scoreboard bench for relu_argmax: stimulus pushes hand-computed results, a monitor pops on handshake.
// Build with RELU_ARGMAX_ZERO_FLAG_EN to also exercise out_all_zero.

module tb_relu_argmax;

    typedef logic [22:0] frame_t [10];
    typedef struct packed {
        logic [3:0]  idx;
        logic [22:0] max;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [22:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_clear = 1'b0;
    logic [3:0]  out_idx;
    logic [22:0] out_max;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef RELU_ARGMAX_ZERO_FLAG_EN
    logic        out_all_zero;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    relu_argmax dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_clear  (in_clear),
        .out_idx   (out_idx),
        .out_max   (out_max),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef RELU_ARGMAX_ZERO_FLAG_EN
        ,
        .out_all_zero (out_all_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed whenever out_valid && out_ready is seen mid-cycle.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual_idx=%0d actual_max=%0d", out_idx, out_max);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_idx", 32'(out_idx), 32'(e.idx));
                check("sb_max", 32'(out_max), 32'(e.max));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Sends the first n beats of f; on a full frame with push set, queues the expected result.
    task automatic send_frame(input frame_t f, input int n, input bit push,
                              input logic [3:0] eidx, input logic [22:0] emax);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = f[i];
            wait_ready();
            if (push && i == 9) begin
                exp_t e;
                e.idx = eidx;
                e.max = emax;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_max", 32'(out_max), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: tie resolves to lower index, one-cycle latency
        out_ready = 1'b1;
        f = '{23'd5, 23'd9, 23'd3, 23'd9, 23'd1, 23'd0, 23'd2, 23'd8, 23'd7, 23'd4};
        send_frame(f, 9, 1'b0, 4'd0, 23'd0);
        check("t1_no_early_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 23'd4;
        sb.push_back('{idx: 4'd1, max: 23'd9});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t1_latency_valid", 32'(out_valid), 32'd1);
        check("t1_hold_in_ready", 32'(in_ready), 32'd0);

        // 2: maximum on the last beat
        f = '{23'd1, 23'd2, 23'd3, 23'd4, 23'd5, 23'd6, 23'd7, 23'd8, 23'd9, 23'd100};
        send_frame(f, 10, 1'b1, 4'd9, 23'd100);

        // 3: back-pressure, all-equal frame -> idx 0
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        f = '{default: 23'd3};
        send_frame(f, 10, 1'b1, 4'd0, 23'd3);
        in_valid = 1'b1;
        in_data  = 23'd999;
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_in_ready", 32'(in_ready), 32'd0);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_idx", 32'(out_idx), 32'd0);
            check("t3_hold_max", 32'(out_max), 32'd3);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_release_valid", 32'(out_valid), 32'd0);
        check("t3_release_in_ready", 32'(in_ready), 32'd1);
        check("t3_keep_max", 32'(out_max), 32'd3);

        // 4: clear drops partial frame and the simultaneous beat
        f = '{23'd50, 23'd60, 23'd70, 23'd80, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0};
        send_frame(f, 4, 1'b0, 4'd0, 23'd0);
        in_valid = 1'b1;
        in_data  = 23'd500;
        in_clear = 1'b1;
        @(posedge clk);
        #1;
        in_clear = 1'b0;
        in_valid = 1'b0;
        check("t4_clear_valid", 32'(out_valid), 32'd0);
        check("t4_clear_in_ready", 32'(in_ready), 32'd1);
        f = '{23'd0, 23'd0, 23'd0, 23'd7, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0};
        send_frame(f, 10, 1'b1, 4'd3, 23'd7);
        @(posedge clk);
        #1;

        // 5: asynchronous reset mid-frame
        f = '{23'd4, 23'd4, 23'd12, 23'd4, 23'd11, 23'd12, 23'd0, 23'd0, 23'd1, 23'd2};
        send_frame(f, 5, 1'b0, 4'd0, 23'd0);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_out_idx", 32'(out_idx), 32'd0);
        check("t5_rst_out_max", 32'(out_max), 32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_frame(f, 10, 1'b1, 4'd2, 23'd12);
        @(posedge clk);
        #1;

`ifdef RELU_ARGMAX_ZERO_FLAG_EN
        // 6: zero-activation flag
        out_ready = 1'b0;
        f = '{default: 23'd0};
        send_frame(f, 10, 1'b1, 4'd0, 23'd0);
        check("t6_all_zero_set", 32'(out_all_zero), 32'd1);
        check("t6_all_zero_idx", 32'(out_idx), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t6_all_zero_cleared", 32'(out_all_zero), 32'd0);
        out_ready = 1'b0;
        f = '{23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd0, 23'd6, 23'd0, 23'd0, 23'd0};
        send_frame(f, 10, 1'b1, 4'd6, 23'd6);
        check("t6_nonzero_flag", 32'(out_all_zero), 32'd0);
        check("t6_nonzero_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
